// File: rtl/key_debouncer.sv
// key_debouncer: turns a raw, bouncy key pin into a clean debounced level
// plus one-cycle press, release and long-press strobes.
// The raw pin passes through a two-flop synchronizer. Samples are then
// debounced by a four-state FSM (IDLE, PRESS_CHK, HELD, REL_CHK).
// Optional feature macro: KEY_REPEAT_EN. When it is defined, long_pulse
// re-fires every REPEAT_CYCLES cycles while the key stays held after the
// first long press.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000,
    parameter logic        KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // Last debounce count value before a level change is accepted.
    localparam logic [CNT_W-1:0] DB_LAST_C   = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Hold counter saturates here.
    localparam logic [CNT_W-1:0] LONG_SAT_C  = CNT_W'(LONG_CYCLES);
    // Value the hold counter takes on the edge that raises long_pulse.
    localparam logic [CNT_W-1:0] LONG_FIRE_C = CNT_W'(LONG_CYCLES - 1);
    // Hold value seen just before the long_pulse edge.
    localparam logic [CNT_W-1:0] LONG_PRE_C  = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);
`ifdef KEY_REPEAT_EN
    // Last repeat count value before the next long_pulse repeat fires.
    localparam logic [CNT_W-1:0] REP_LAST_C  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             sync_q1_r;
    logic             sync_q2_r;
    logic             sample_s;
    state_t           state_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_next_s;
    logic             long_hit_s;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_r;
    logic [CNT_W-1:0] rep_next_s;
    logic             rep_hit_s;
`endif

    // Sample is 1 when the synchronized pin shows the key pressed.
    assign sample_s = sync_q2_r ^ KEY_ACTIVE_LOW;

    // Next hold count (saturating) and long-press strobe decision for HELD.
    always_comb begin
        hold_next_s = hold_cnt_r;
        long_hit_s  = 1'b0;
        if (hold_cnt_r != LONG_SAT_C) begin
            hold_next_s = hold_cnt_r + CNT_ONE_C;
        end else begin
            hold_next_s = hold_cnt_r;
        end
`ifdef KEY_REPEAT_EN
        rep_next_s = rep_cnt_r;
        rep_hit_s  = 1'b0;
        // Repeat timing only runs once the first long press has fired.
        if (hold_cnt_r >= LONG_FIRE_C) begin
            if (rep_cnt_r == REP_LAST_C) begin
                rep_hit_s  = 1'b1;
                rep_next_s = CNT_ZERO_C;
            end else begin
                rep_hit_s  = 1'b0;
                rep_next_s = rep_cnt_r + CNT_ONE_C;
            end
        end else begin
            rep_hit_s  = 1'b0;
            rep_next_s = rep_cnt_r;
        end
        long_hit_s = (hold_cnt_r == LONG_PRE_C) | rep_hit_s;
`else
        long_hit_s = (hold_cnt_r == LONG_PRE_C);
`endif
    end

    // Synchronizer, debounce FSM, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1_r     <= KEY_ACTIVE_LOW;
            sync_q2_r     <= KEY_ACTIVE_LOW;
            state_r       <= IDLE;
            db_cnt_r      <= CNT_ZERO_C;
            hold_cnt_r    <= CNT_ZERO_C;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_r     <= CNT_ZERO_C;
`endif
        end else begin
            sync_q1_r     <= key_in;
            sync_q2_r     <= sync_q1_r;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sample_s) begin
                        state_r  <= PRESS_CHK;
                        db_cnt_r <= CNT_ONE_C;
                    end else begin
                        db_cnt_r <= CNT_ZERO_C;
                    end
                end
                PRESS_CHK: begin
                    if (!sample_s) begin
                        state_r  <= IDLE;
                        db_cnt_r <= CNT_ZERO_C;
                    end else if (db_cnt_r == DB_LAST_C) begin
                        state_r     <= HELD;
                        db_cnt_r    <= CNT_ZERO_C;
                        hold_cnt_r  <= CNT_ZERO_C;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        db_cnt_r <= db_cnt_r + CNT_ONE_C;
                    end
                end
                HELD: begin
                    hold_cnt_r <= hold_next_s;
                    long_pulse <= long_hit_s;
`ifdef KEY_REPEAT_EN
                    rep_cnt_r  <= rep_next_s;
`endif
                    if (!sample_s) begin
                        state_r  <= REL_CHK;
                        db_cnt_r <= CNT_ONE_C;
                    end else begin
                        db_cnt_r <= CNT_ZERO_C;
                    end
                end
                REL_CHK: begin
                    // Hold (and repeat) counters are frozen here.
                    if (sample_s) begin
                        state_r  <= HELD;
                        db_cnt_r <= CNT_ZERO_C;
                    end else if (db_cnt_r == DB_LAST_C) begin
                        state_r       <= IDLE;
                        db_cnt_r      <= CNT_ZERO_C;
                        hold_cnt_r    <= CNT_ZERO_C;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_cnt_r     <= CNT_ZERO_C;
`endif
                    end else begin
                        db_cnt_r <= db_cnt_r + CNT_ONE_C;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    db_cnt_r   <= CNT_ZERO_C;
                    hold_cnt_r <= CNT_ZERO_C;
                    key_level  <= 1'b0;
`ifdef KEY_REPEAT_EN
                    rep_cnt_r  <= CNT_ZERO_C;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer.
// Two instances share one stimulus stream. The active-low instance gets the
// pin directly. The active-high instance gets the inverted pin, so both must
// behave identically. A run-length reference model predicts every output on
// every cycle.
module tb_key_debouncer;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic reset;
    logic key_in;
    logic key_in_b;
    logic a_level, a_press, a_rel, a_long;
    logic b_level, b_press, b_rel, b_long;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pin history per edge, last reset edge, accepted level,
    // press edge and number of HELD cycles since the press.
    bit pin_hist [0:4095];
    int t         = -1;
    int r_last    = 0;
    bit lvl_m     = 1'b0;
    int t_press_m = 0;
    int held_m    = 0;

    assign key_in_b = ~key_in;

    key_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
                    .KEY_ACTIVE_LOW(1'b1), .CNT_W(8)) u_dut_low (
        .clk(clk), .reset(reset), .key_in(key_in), .key_level(a_level),
        .press_pulse(a_press), .release_pulse(a_rel), .long_pulse(a_long));

    key_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
                    .KEY_ACTIVE_LOW(1'b0), .CNT_W(8)) u_dut_high (
        .clk(clk), .reset(reset), .key_in(key_in_b), .key_level(b_level),
        .press_pulse(b_press), .release_pulse(b_rel), .long_pulse(b_long));

    always #5 clk = ~clk;

    // Pressed sample seen by the debouncer at edge e. Two edges of
    // synchronizer delay apply, and the synchronizer holds "released"
    // after a reset.
    function automatic bit s_at(input int e);
        if (e - 2 > r_last) return !pin_hist[e - 2];
        else return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic step(input bit pin, input bit rst);
        bit e_press, e_rel, e_long, run_ok, held_state;
        key_in = pin;
        reset  = rst;
        @(posedge clk);
        #1;
        t++;
        pin_hist[t] = pin;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (rst) begin
            r_last = t;
            lvl_m  = 1'b0;
            held_m = 0;
        end else begin
            held_state = lvl_m && ((t - 1 == t_press_m) || s_at(t - 1));
            run_ok = 1'b1;
            for (int j = 0; j < D; j++) begin
                if ((t - j <= r_last) || (s_at(t - j) == lvl_m)) run_ok = 1'b0;
            end
            if (run_ok && !lvl_m) begin
                lvl_m     = 1'b1;
                e_press   = 1'b1;
                t_press_m = t;
                held_m    = 0;
            end else if (run_ok && lvl_m) begin
                lvl_m = 1'b0;
                e_rel = 1'b1;
            end else if (held_state) begin
                held_m++;
                e_long = (held_m == L - 1);
`ifdef KEY_REPEAT_EN
                if (held_m > L - 1 && ((held_m - (L - 1)) % R) == 0) e_long = 1'b1;
`endif
            end
        end
        check("level_lo",   a_level, lvl_m);
        check("press_lo",   a_press, e_press);
        check("release_lo", a_rel,   e_rel);
        check("long_lo",    a_long,  e_long);
        check("level_hi",   b_level, lvl_m);
        check("press_hi",   b_press, e_press);
        check("release_hi", b_rel,   e_rel);
        check("long_hi",    b_long,  e_long);
    endtask

    task automatic hold_pin(input bit pin, input int n);
        for (int i = 0; i < n; i++) step(pin, 1'b0);
    endtask

    initial begin
        int seg_len;
        bit seg_lvl;
        key_in = 1'b1;
        reset  = 1'b1;
        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        hold_pin(1'b1, 3);
        // Clean press held 40 cycles, then release.
        hold_pin(1'b0, 40);
        hold_pin(1'b1, 10);
        // Bounce rejection: no run reaches D samples.
        hold_pin(1'b0, 3);
        hold_pin(1'b1, 2);
        hold_pin(1'b0, 3);
        hold_pin(1'b1, 10);
        // Release with a 2-cycle low glitch inside the release window.
        hold_pin(1'b0, 30);
        hold_pin(1'b1, 2);
        hold_pin(1'b0, 2);
        hold_pin(1'b1, 10);
        // Reset in the middle of a hold while the key stays down.
        hold_pin(1'b0, 15);
        step(1'b0, 1'b1);
        hold_pin(1'b0, 15);
        hold_pin(1'b1, 10);
        // Long hold for long-press and repeat behaviour.
        hold_pin(1'b0, 70);
        hold_pin(1'b1, 10);
        // Randomized bouncy segments with occasional resets.
        for (int k = 0; k < 250; k++) begin
            seg_lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) seg_len = $urandom_range(15, 40);
            else seg_len = $urandom_range(1, 6);
            if ($urandom_range(0, 59) == 0) step(seg_lvl, 1'b1);
            hold_pin(seg_lvl, seg_len);
        end
        hold_pin(1'b1, 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart to the board LED drivers. Takes a raw, bouncy pushbutton or slide-switch level from a board pin.
- Produces a clean, synchronized level plus single-cycle press, release and long-press strobes for HPS-facing or fabric logic.
- One instance per physical key. Placed next to the blinker and status logic in the common board top level.

Parameters:
- DEBOUNCE_CYCLES, 2500000, consecutive identical samples required to accept a level change (50 ms at 50 MHz); legal range is 2 or more.
- LONG_CYCLES, 50000000, cycles the key must be held, counted from the press_pulse cycle, before long_pulse fires (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 12500000, auto-repeat period after long press; used only with KEY_REPEAT_EN.
- KEY_ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.
- CNT_W, 26, width of the internal counters; must hold LONG_CYCLES.

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high reset
- key_in  in  1  raw asynchronous pin level
- key_level  out  1  debounced level, 1 = pressed
- press_pulse  out  1  one-cycle strobe on accepted press
- release_pulse  out  1  one-cycle strobe on accepted release
- long_pulse  out  1  one-cycle strobe when the hold reaches LONG_CYCLES (and repeats, if enabled)

Behaviour:
- Synchronizer: two-flop chain on key_in.
  - Sample s = sync_q2 XOR KEY_ACTIVE_LOW, so s = 1 means pressed.
  - Synchronizer flops reset to the released pin level.
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK. Reset gives IDLE, both counters 0, all outputs 0.
- IDLE: when s=1, go to PRESS_CHK with db_cnt=1.
- PRESS_CHK:
  - s=1: increment db_cnt.
  - When db_cnt reaches DEBOUNCE_CYCLES: go to HELD, set key_level=1, pulse press_pulse for 1 cycle, set hold_cnt=0.
  - s=0 at any point: return to IDLE, db_cnt=0, no pulse.
- HELD:
  - hold_cnt increments each cycle and saturates at LONG_CYCLES.
  - On the cycle hold_cnt reaches LONG_CYCLES-1: long_pulse=1 for 1 cycle. Fires at most once per press.
  - s=0: go to REL_CHK with db_cnt=1.
- REL_CHK:
  - s=0: increment db_cnt.
  - When db_cnt reaches DEBOUNCE_CYCLES: go to IDLE, key_level=0, release_pulse for 1 cycle.
  - s=1 before then: return to HELD. hold_cnt keeps its value; it is frozen while in REL_CHK.
  - key_level stays 1 throughout REL_CHK.
- Latency: a clean edge on key_in appears at key_level exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples the new level (2 synchronizer edges + DEBOUNCE_CYCLES).
- Strobe alignment:
  - press_pulse and the key_level rise share the same cycle.
  - release_pulse and the key_level fall share the same cycle.
- Pulse exclusivity: press_pulse, release_pulse and long_pulse are mutually exclusive in any one cycle.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Reset mid-operation: reset asserted in any state gives IDLE on the next edge, key_level=0, no release_pulse emitted, synchronizer reloaded.
  - A key still held when reset deasserts is re-debounced and produces a fresh press_pulse.
- Counters: all compares are exact equality.
  - db_cnt never exceeds DEBOUNCE_CYCLES.
  - hold_cnt never exceeds LONG_CYCLES.
  - No wrap-around is possible.

Optional Feature:
- Macro: KEY_REPEAT_EN
- Defined:
  - After the first long_pulse, HELD additionally runs rep_cnt.
  - long_pulse re-fires every REPEAT_CYCLES cycles while in HELD.
  - rep_cnt freezes in REL_CHK and clears on entry to IDLE.
- Undefined: no rep_cnt logic; long_pulse fires at most once per press.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, KEY_ACTIVE_LOW=1):
- Clean press: key_in 1 to 0 held 40 cycles -> key_level rises and press_pulse=1 exactly 6 edges after the first sampling edge; long_pulse exactly once, 19 cycles after press_pulse; no other pulses.
- Bounce reject: key_in low 3 cycles, high 2 cycles, low 3 cycles, then high -> key_level stays 0, no pulses of any kind.
- Release bounce: key held, then released with a 2-cycle low glitch inside the release window, then high 10 cycles -> key_level stays 1 through the glitch; single release_pulse 4 edges after the last glitch sample clears; long_pulse not duplicated.
- Reset mid-hold: reset=1 for 1 cycle while in HELD with key still low -> key_level=0 next cycle, no release_pulse; after reset drops, press_pulse again 6 edges later.
- Polarity: KEY_ACTIVE_LOW=0, key_in 0 to 1 held 10 cycles -> press_pulse after 6 edges, key_level=1.
- KEY_REPEAT_EN defined: key held 60 cycles -> long_pulse at 19, 27, 35, 43, 51 cycles after press_pulse; undefined -> only at 19.
